// File: rtl/dram_req_queue.sv
// In-order DRAM request queue: circular FIFO whose head issues once the cycle counter reaches its timestamp.
// Define DRAM_REQ_QUEUE_TIME_SKIP_EN to let an idle queue jump the cycle counter to the first request's time.
module dram_req_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 36,
    parameter int TIME_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TIME_W-1:0]        in_time,
    input  logic [1:0]               in_op,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic                     in_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TIME_W-1:0]        out_time,
    output logic [1:0]               out_op,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [TIME_W-1:0]        cycle,
    output logic                     err_op,
    output logic                     drained
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [1:0]        OP_ILLEGAL = 2'd3;
    localparam logic [TIME_W-1:0] TIME_MAX   = '1;

    logic [TIME_W-1:0] r_memTime [DEPTH];
    logic [1:0]        r_memOp   [DEPTH];
    logic [ADDR_W-1:0] r_memAddr [DEPTH];

    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [TIME_W-1:0] r_cycle;
    logic              r_errOp;
    logic              r_drained;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_drop;
    logic              w_valid;
    logic              w_pop;
    logic [TIME_W-1:0] w_headTime;

    // Status flags come only from registered occupancy, so in_ready never depends on out_ready.
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_accept   = in_valid && !w_full;
    assign w_push     = w_accept && (in_op != OP_ILLEGAL);
    assign w_drop     = w_accept && (in_op == OP_ILLEGAL);
    assign w_headTime = r_memTime[r_rdPtr];
    assign w_valid    = !w_empty && (r_cycle >= w_headTime);
    assign w_pop      = w_valid && out_ready;

    assign in_ready  = !w_full;
    assign out_valid = w_valid;
    assign out_time  = w_headTime;
    assign out_op    = r_memOp[r_rdPtr];
    assign out_addr  = r_memAddr[r_rdPtr];
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign cycle     = r_cycle;
    assign err_op    = r_errOp;
    assign drained   = r_drained;

    // Entry storage is never cleared; reset only forgets it through the pointers and count.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_memTime[r_wrPtr] <= in_time;
            r_memOp[r_wrPtr]   <= in_op;
            r_memAddr[r_wrPtr] <= in_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle <= '0;
`ifdef DRAM_REQ_QUEUE_TIME_SKIP_EN
        end else if (w_empty && w_push && (in_time > r_cycle)) begin
            r_cycle <= in_time;
`endif
        end else if (r_cycle != TIME_MAX) begin
            r_cycle <= r_cycle + TIME_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_errOp   <= 1'b0;
            r_drained <= 1'b0;
        end else begin
            r_errOp   <= w_drop;
            r_drained <= in_done && w_empty && !in_valid;
        end
    end

    // Structural invariants of the circular buffer.
    assert property (@(posedge clock) disable iff (reset) r_count <= FULL_CNT);
    assert property (@(posedge clock) disable iff (reset) w_full |-> !w_push);
    assert property (@(posedge clock) disable iff (reset)
                     PTR_W'(r_wrPtr - r_rdPtr) == r_count[PTR_W-1:0]);

endmodule

// File: tb/tb_dram_req_queue.sv
// Directed bench for dram_req_queue (DEPTH=4): expected entries are queued at issue and checked by a pop monitor.
module tb_dram_req_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 36;
    localparam int TIME_W = 32;

    typedef struct packed {
        logic [TIME_W-1:0] t;
        logic [1:0]        op;
        logic [ADDR_W-1:0] a;
    } entry_t;

    logic                     clock;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [TIME_W-1:0]        in_time;
    logic [1:0]               in_op;
    logic [ADDR_W-1:0]        in_addr;
    logic                     in_done;
    logic                     out_valid;
    logic                     out_ready;
    logic [TIME_W-1:0]        out_time;
    logic [1:0]               out_op;
    logic [ADDR_W-1:0]        out_addr;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic [TIME_W-1:0]        cycle;
    logic                     err_op;
    logic                     drained;

    entry_t sbQ[$];
    entry_t monExp;
    int     checks = 0;
    int     fails  = 0;

    dram_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIME_W(TIME_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
        .in_op(in_op), .in_addr(in_addr), .in_done(in_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time),
        .out_op(out_op), .out_addr(out_addr),
        .full(full), .empty(empty), .count(count), .cycle(cycle),
        .err_op(err_op), .drained(drained)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void checkOutput(input string name, input logic [63:0] actual,
                                        input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one request, wait for in_ready, and record what the queue should later issue.
    task automatic applyStimulus(input logic [TIME_W-1:0] t, input logic [1:0] op,
                                 input logic [ADDR_W-1:0] a);
        entry_t e;
        int waited = 0;
        in_valid = 1'b1;
        in_time  = t;
        in_op    = op;
        in_addr  = a;
        @(negedge clock);
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("[TB] FAIL push_timeout: in_ready stayed 0, expected 1");
        end else if (op != 2'd3) begin
            e.t = t;
            e.op = op;
            e.a = a;
            sbQ.push_back(e);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drainQueue(input int bound);
        int k = 0;
        out_ready = 1'b1;
        while (sbQ.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        checks++;
        if (sbQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", sbQ.size());
        end
        checkOutput("drain_empty", 64'(empty), 64'd1);
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_pop: addr 0x%0h issued, expected none", out_addr);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("pop_time", 64'(out_time), 64'(monExp.t));
                checkOutput("pop_op",   64'(out_op),   64'(monExp.op));
                checkOutput("pop_addr", 64'(out_addr), 64'(monExp.a));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_time   = '0;
        in_op     = '0;
        in_addr   = '0;
        in_done   = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        checkOutput("rst_count",    64'(count),     64'd0);
        checkOutput("rst_empty",    64'(empty),     64'd1);
        checkOutput("rst_full",     64'(full),      64'd0);
        checkOutput("rst_outvalid", 64'(out_valid), 64'd0);
        checkOutput("rst_errop",    64'(err_op),    64'd0);
        checkOutput("rst_drained",  64'(drained),   64'd0);
        checkOutput("rst_cycle",    64'(cycle),     64'd0);
        checkOutput("rst_inready",  64'(in_ready),  64'd1);

        // First request at cycle 3 becomes eligible at cycle 4
        repeat (3) tick();
        checkOutput("pre_cycle",    64'(cycle),     64'd3);
        checkOutput("pre_outvalid", 64'(out_valid), 64'd0);
        applyStimulus(32'd0, 2'd0, 36'h1_2345_6789);
        checkOutput("first_cycle",    64'(cycle),     64'd4);
        checkOutput("first_outvalid", 64'(out_valid), 64'd1);
        checkOutput("first_count",    64'(count),     64'd1);
        checkOutput("first_addr",     64'(out_addr),  64'h1_2345_6789);
        drainQueue(10);

        // Illegal op is dropped with a single err_op pulse
        applyStimulus(32'd0, 2'd3, 36'hBAD);
        checkOutput("illegal_errop", 64'(err_op), 64'd1);
        checkOutput("illegal_count", 64'(count),  64'd0);
        tick();
        checkOutput("illegal_pulse", 64'(err_op), 64'd0);
        applyStimulus(32'd0, 2'd1, 36'hA_BCDE_F012);
        checkOutput("after_illegal_count", 64'(count),  64'd1);
        checkOutput("after_illegal_op",    64'(out_op), 64'd1);
        drainQueue(10);

        // Fill to DEPTH, hold a fifth, pop one at full
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'd0, 2'(i % 3), 36'h10 + 36'(i));
        end
        checkOutput("fill_full",    64'(full),     64'd1);
        checkOutput("fill_inready", 64'(in_ready), 64'd0);
        checkOutput("fill_count",   64'(count),    64'd4);
        in_valid = 1'b1;
        in_time  = 32'd0;
        in_op    = 2'd1;
        in_addr  = 36'h14;
        tick();
        checkOutput("held_count1", 64'(count), 64'd4);
        tick();
        checkOutput("held_count2", 64'(count), 64'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("popfull_count",   64'(count),    64'd3);
        checkOutput("popfull_inready", 64'(in_ready), 64'd1);
        begin
            entry_t e;
            e.t = 32'd0;
            e.op = 2'd1;
            e.a = 36'h14;
            sbQ.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        checkOutput("fifth_count", 64'(count), 64'd4);
        checkOutput("fifth_full",  64'(full),  64'd1);
        drainQueue(20);

        // Steady push+pop at occupancy 3, wrapping the pointers
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'd0, 2'd2, 36'h20 + 36'(i));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            entry_t e;
            in_valid = 1'b1;
            in_time  = 32'd0;
            in_op    = 2'(i % 3);
            in_addr  = 36'h30 + 36'(i);
            e.t = in_time;
            e.op = in_op;
            e.a = in_addr;
            sbQ.push_back(e);
            tick();
            checkOutput("steady_count", 64'(count), 64'd3);
        end
        in_valid = 1'b0;
        drainQueue(20);

        // drained follows in_done once the queue empties
        in_done = 1'b1;
        applyStimulus(32'd0, 2'd0, 36'h40);
        applyStimulus(32'd0, 2'd1, 36'h41);
        checkOutput("drained_busy", 64'(drained), 64'd0);
        drainQueue(10);
        checkOutput("drained_lag", 64'(drained), 64'd0);
        tick();
        checkOutput("drained_set", 64'(drained), 64'd1);
        in_done = 1'b0;
        tick();
        checkOutput("drained_clear", 64'(drained), 64'd0);

        // Reset mid-stream discards entries and ignores a same-cycle push
        applyStimulus(32'd0, 2'd0, 36'h50);
        applyStimulus(32'd0, 2'd0, 36'h51);
        checkOutput("mid_count", 64'(count), 64'd2);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_addr  = 36'h52;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        sbQ.delete();
        checkOutput("midrst_empty",    64'(empty),     64'd1);
        checkOutput("midrst_outvalid", 64'(out_valid), 64'd0);
        checkOutput("midrst_count",    64'(count),     64'd0);
        checkOutput("midrst_cycle",    64'(cycle),     64'd0);
        tick();
        checkOutput("midrst_nopush", 64'(count), 64'd0);
        checkOutput("midrst_cycle1", 64'(cycle), 64'd1);

        // Future timestamp: wait for the counter, or jump to it when time-skip is built in
        repeat (9) tick();
        checkOutput("future_start", 64'(cycle), 64'd10);
        applyStimulus(32'd50, 2'd0, 36'h60);
`ifdef DRAM_REQ_QUEUE_TIME_SKIP_EN
        checkOutput("skip_cycle",    64'(cycle),     64'd50);
        checkOutput("skip_outvalid", 64'(out_valid), 64'd1);
`else
        checkOutput("wait_cycle",    64'(cycle),     64'd11);
        checkOutput("wait_outvalid", 64'(out_valid), 64'd0);
        repeat (38) tick();
        checkOutput("wait_49", 64'(out_valid), 64'd0);
        tick();
        checkOutput("wait_50",       64'(out_valid), 64'd1);
        checkOutput("wait_cycle50",  64'(cycle),     64'd50);
`endif
        drainQueue(10);

        // An ineligible head blocks eligible entries behind it
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(32'd0,  2'd0, 36'h70);
        applyStimulus(32'd20, 2'd2, 36'h71);
        applyStimulus(32'd0,  2'd1, 36'h72);
        out_ready = 1'b1;
        tick();
        checkOutput("block_outvalid", 64'(out_valid), 64'd0);
        checkOutput("block_count",    64'(count),     64'd2);
        checkOutput("block_time",     64'(out_time),  64'd20);
        checkOutput("block_addr",     64'(out_addr),  64'h71);
        repeat (15) tick();
        checkOutput("block_19_valid", 64'(out_valid), 64'd0);
        checkOutput("block_19_count", 64'(count),     64'd2);
        tick();
        checkOutput("block_20_valid", 64'(out_valid), 64'd1);
        drainQueue(10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dram_req_queue.md
DRAM_REQ_QUEUE -- requirements
Module: dram_req_queue

Interface
REQ-001 Parameter DEPTH, default 16, sets the number of request entries; it SHALL be a power of two, at least 2.
REQ-002 Parameter ADDR_W, default 36, sets the request address width in bits.
REQ-003 Parameter TIME_W, default 32, sets the timestamp and cycle-counter width in bits.
REQ-004 Port clock, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port in_valid, input, 1, request offered by the trace reader.
REQ-007 Port in_ready, output, 1, the queue accepts a request this cycle.
REQ-008 Port in_time, input, TIME_W, earliest issue cycle of the request.
REQ-009 Port in_op, input, 2, request type: 0 = read, 1 = write, 2 = instruction fetch, 3 = illegal.
REQ-010 Port in_addr, input, ADDR_W, request address.
REQ-011 Port in_done, input, 1, level signal: the trace reader has no further requests.
REQ-012 Port out_valid, output, 1, the head request is eligible for issue.
REQ-013 Port out_ready, input, 1, the memory controller takes the head request.
REQ-014 Ports out_time, out_op and out_addr, outputs, TIME_W, 2 and ADDR_W, the head entry's fields.
REQ-015 Port full, output, 1, occupancy equals DEPTH.
REQ-016 Port empty, output, 1, occupancy equals 0.
REQ-017 Port count, output, clog2(DEPTH)+1, the current occupancy.
REQ-018 Port cycle, output, TIME_W, the free-running cycle counter.
REQ-019 Port err_op, output, 1, one-cycle pulse when an illegal op is dropped.
REQ-020 Port drained, output, 1, all work is complete.

Function
REQ-021 The queue SHALL be a circular FIFO with write pointer, read pointer and a separate occupancy counter.
REQ-022 in_ready SHALL equal !full, taken from registered state only, with no combinational path from out_ready.
REQ-023 A push SHALL occur when in_valid && in_ready && in_op != 3; the entry SHALL be visible at the head no earlier than the next cycle.
REQ-024 When in_valid && in_ready && in_op == 3, the request SHALL be consumed but not stored, and err_op SHALL pulse on the next cycle.
REQ-025 cycle SHALL increment by 1 every cycle and saturate at its all-ones value.
REQ-026 out_valid SHALL equal !empty && (cycle >= head time), using an unsigned compare.
REQ-027 A pop SHALL occur when out_valid && out_ready.
REQ-028 out_time, out_op and out_addr SHALL present the head entry whenever !empty, regardless of out_valid.
REQ-029 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-030 A push SHALL be impossible when full, including in a cycle where a pop occurs at full.
REQ-031 out_ready asserted while out_valid is 0 SHALL have no effect.
REQ-032 Pointers SHALL wrap modulo DEPTH.
REQ-033 Requests SHALL issue strictly in arrival order.
REQ-034 A head entry that is not yet eligible SHALL block all later entries behind it.
REQ-035 drained SHALL be registered and equal in_done && empty && !in_valid; it SHALL deassert if in_done drops.

Reset
REQ-036 On reset, the pointers, count and cycle SHALL clear to 0.
REQ-037 On reset, full = 0, empty = 1, out_valid = 0, err_op = 0 and drained = 0.
REQ-038 Reset asserted mid-operation SHALL discard all stored entries; entry storage itself need not be cleared.
REQ-039 A push in the same cycle as reset SHALL be ignored.

Configuration
REQ-040 Macro DRAM_REQ_QUEUE_TIME_SKIP_EN SHALL compile the time-skip feature in or out.
REQ-041 With the macro defined: when empty, a push that occurs with in_time > cycle SHALL also load cycle with in_time on that edge, so the entry is eligible on the next cycle.
REQ-042 With the macro undefined: cycle SHALL only increment or saturate, and the module SHALL have no extra logic.

Verification
REQ-043 Reset, then push (time 0, op 0, addr 0x1_2345_6789) at cycle 3 -> out_valid = 1 at cycle 4, head fields match, count = 1.
REQ-044 DEPTH = 4, push 5 requests with time 0 and out_ready = 0 -> full = 1 after the 4th push, in_ready = 0, the 5th request is held; pop one -> the 5th is accepted on the next cycle; order is preserved.
REQ-045 Push time 50 at cycle 10 with the macro undefined -> out_valid stays 0 until cycle 50; with the macro defined -> cycle = 50 and out_valid = 1 at cycle 11.
REQ-046 Push op 3 -> err_op pulses once, count unchanged; a following op 1 request is stored normally.
REQ-047 Fill 3, then push and pop together for 20 cycles -> count stays 3, pointers wrap, output order equals input order.
REQ-048 Assert in_done with 2 entries queued; pop both -> drained = 1 the cycle after empty; reset mid-stream -> empty = 1 and out_valid = 0 the next cycle.
